seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed scanner for the board's DIGITS-digit common-anode seven-segment display. It sits directly upstream of the hex decoder `Seg`: it selects one nibble per scan slot, drives it on `d` into `Seg`, and drives the matching active-low anode and decimal point. Input data is shadowed once per frame, so a frame never mixes old and new digits. It also provides per-digit enable, blink and anti-ghosting blanking.

## Interface
- `DIGITS`, 8: number of digits, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥2. At 100 MHz this gives 2 kHz per slot and a 250 Hz frame.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off, 0 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_FRAMES`, 125: frames per blink half-period, ≥1.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data` in 4*DIGITS: nibble i = `data[4i+3:4i]` is shown on digit i.
- `en_mask` in DIGITS: 1 enables digit i. A disabled digit's anode stays high.
- `dp_mask` in DIGITS: 1 lights the decimal point on digit i.
- `blink_mask` in DIGITS: 1 makes digit i blink.
- `d` out 4: nibble of the current digit, fed to `Seg.d`.
- `an_n` out DIGITS: active-low anodes, at most one low.
- `dp_n` out 1: active-low decimal point.
- `frame_start` out 1: one-cycle pulse when the shadow registers reload.

## Operation
- **Registers:**
  - `div_cnt` counts 0..SCAN_DIV-1.
  - `idx` counts 0..DIGITS-1.
  - `frm_cnt` counts 0..BLINK_FRAMES-1.
  - `blink_ph` is 1 bit.
  - Shadow registers `sh_data`, `sh_en`, `sh_dp`, `sh_blink`.
- `tick` = (`div_cnt` == SCAN_DIV-1). On tick, `div_cnt`→0; otherwise `div_cnt`+1.
- On tick, `idx` advances. From DIGITS-1 it wraps to 0.
- **Frame wrap** = `tick` && `idx` == DIGITS-1. On the wrap edge:
  - All four shadows load from the inputs.
  - `frame_start` is registered high for exactly the next cycle.
  - `frm_cnt` advances. When it wraps from BLINK_FRAMES-1 to 0, `blink_ph` toggles.
- Inputs are sampled only at frame wrap. Input changes at any other time have no visible effect until the next frame.
- **Outputs** are decoded from registers only; there is no combinational path from any input:
  - `d` = `sh_data[4*idx +: 4]` at all times, including during blanking.
  - `an_n[i]` = 0 iff all of the following hold: i == `idx`, `sh_en[i]` = 1, `div_cnt` ≥ BLANK_CYC, and not (`sh_blink[i]` && `blink_ph`).
  - `dp_n` = ~(`sh_dp[idx]` && `an_n[idx]` == 0). The dp is never lit while the anode is off.
- **Reset** (async, any time, including mid-slot):
  - Counters, `blink_ph` and all shadows go to 0.
  - `an_n` = all 1, `dp_n` = 1, `d` = 0, `frame_start` = 0.
- **After reset release:**
  - First slot is digit 0, with all anodes dark because the shadows are 0.
  - The first frame wrap, after DIGITS×SCAN_DIV cycles, loads real data.

## Timing
- Slot length: exactly SCAN_DIV cycles. Frame length: DIGITS×SCAN_DIV cycles.
- Within a slot, the anode is low for SCAN_DIV−BLANK_CYC cycles, starting at `div_cnt` = BLANK_CYC.
- The `idx` change and the shadow load happen on the same edge. The first slot of a new frame therefore already shows the new data.
- Blink period: 2×BLINK_FRAMES frames, 50% duty. The first dark phase starts after BLINK_FRAMES frame wraps from reset.
- DIGITS = 1: every tick is a frame wrap, and `idx` stays 0.
- BLANK_CYC = 0: the anode is low for the whole slot.

## Test plan
Bench parameters: DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.

- **Reset:** assert `rst` mid-slot with the anode low → `an_n` goes to 8'hFF, `dp_n` to 1 and `d` to 0 with no clock edge. After release, `an_n` stays 8'hFF for 32 cycles.
- **Scan order:** `data`=32'h76543210, `en_mask`=8'hFF. After the first frame wrap, slot k shows `d`=k. `an_n` = ~(1<<k) for cycles 1..3 of the slot and 8'hFF in cycle 0. The sequence repeats every 32 cycles.
- **Frame coherence:** change `data` to 32'hFEDCBA98 while digit 3 is shown → digits 4..7 of that frame still show 4..7. The next frame shows 8..F. `frame_start` pulses once per 32 cycles.
- **Enable and dp:** `en_mask`=8'h0F, `dp_mask`=8'h05 → `an_n` is never low for digits 4..7. `dp_n`=0 only while digits 0 or 2 are lit.
- **Blink:** `blink_mask`=8'h01 → digit 0 is lit in frames 1–2, dark in frames 3–4, lit in frames 5–6. The other digits are unaffected.
- **Single digit:** a DIGITS=1 build has `frame_start` every 4 cycles, and `an_n` alternates 1,0,0,0.

Source files
------------

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a common-anode seven-segment display.
// Shadows the digit data once per frame and drives nibble, anodes and dp.
module seg_scan #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     en_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            d,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  frame_start
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]       div_cnt;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       frm_cnt;
    logic                blink_ph;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_en;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blink;

    logic tick;
    logic wrap;
    logic blank_ok;

    assign tick     = (div_cnt == DW'(SCAN_DIV - 1));
    assign wrap     = tick && (idx == IW'(DIGITS - 1));
    assign blank_ok = (div_cnt >= DW'(BLANK_CYC));

    // Slot divider, digit index, frame/blink counters and per-frame shadows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            frm_cnt     <= '0;
            blink_ph    <= 1'b0;
            sh_data     <= '0;
            sh_en       <= '0;
            sh_dp       <= '0;
            sh_blink    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (tick) begin
                div_cnt <= '0;
                if (idx == IW'(DIGITS - 1)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (wrap) begin
                sh_data  <= data;
                sh_en    <= en_mask;
                sh_dp    <= dp_mask;
                sh_blink <= blink_mask;
                if (frm_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frm_cnt  <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    frm_cnt <= frm_cnt + FW'(1);
                end
            end
        end
    end

    // Output decode from registers only; dp follows the anode so it is never lit in the dark
    always_comb begin
        d    = 4'h0;
        an_n = '1;
        dp_n = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx) begin
                d       = sh_data[4*i +: 4];
                an_n[i] = ~(sh_en[i] && blank_ok && !(sh_blink[i] && blink_ph));
                dp_n    = ~(sh_dp[i] && !an_n[i]);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: an 8-digit build and a single-digit build run side by side.
module tb_seg_scan;

    typedef struct {
        int         n;
        logic [3:0] d;
        logic [7:0] an;
        logic       dp;
        logic       fs;
        logic [3:0] d1;
        logic       an1;
        logic       dp1;
        logic       fs1;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [31:0] data;
    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic [7:0] blink_mask;
    logic [3:0] d;
    logic [7:0] an_n;
    logic       dp_n;
    logic       frame_start;

    logic [3:0] data1;
    logic       en1;
    logic       dpm1;
    logic       blink1;
    logic [3:0] d1;
    logic       an1;
    logic       dp1;
    logic       fs1;

    int   n_cmp;
    int   n_bad;
    bit   mon_en;
    exp_t q[$];

    // Per-frame input plan; entry f is what the shadows hold during frame f
    logic [31:0] p_data  [9] = '{32'h0, 32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'h76543210,
                                 32'hFEDCBA98, 32'h76543210, 32'h76543210, 32'h76543210};
    logic [7:0]  p_en    [9] = '{8'h00, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  p_dp    [9] = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0]  p_blink [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};

    seg_scan #(.DIGITS(8), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) u_dut (
        .clk(clk), .rst(rst), .data(data), .en_mask(en_mask), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .d(d), .an_n(an_n), .dp_n(dp_n), .frame_start(frame_start)
    );

    seg_scan #(.DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) u_one (
        .clk(clk), .rst(rst), .data(data1), .en_mask(en1), .dp_mask(dpm1),
        .blink_mask(blink1), .d(d1), .an_n(an1), .dp_n(dp1), .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at n=%0d: got %h, expected %h", nm, n, act, exp);
        end
    endtask

    task automatic apply(input int f);
        data       = p_data[f];
        en_mask    = p_en[f];
        dp_mask    = p_dp[f];
        blink_mask = p_blink[f];
    endtask

    // Expected outputs for the sample taken n clock edges after reset release
    function automatic exp_t model(input int n);
        exp_t        e;
        int          f;
        int          k;
        int          c;
        bit          ph;
        bit          lit;
        bit          lit1;
        logic [31:0] dv;
        logic [7:0]  en;
        logic [7:0]  dpm;
        logic [7:0]  bl;
        logic [7:0]  one;
        f   = n / 32;
        k   = (n / 4) % 8;
        c   = n % 4;
        ph  = ((f / 2) % 2) == 1;
        dv  = p_data[f];
        en  = p_en[f];
        dpm = p_dp[f];
        bl  = p_blink[f];
        one = 8'h01;
        lit = en[k] && (c >= 1) && !(bl[k] && ph);
        e.n  = n;
        e.d  = 4'(dv >> (4 * k));
        e.an = lit ? ~(one << k) : 8'hFF;
        e.dp = !(lit && dpm[k]);
        e.fs = (n > 0) && (n % 32 == 0);
        lit1  = (n >= 4) && (c >= 1);
        e.d1  = (n >= 4) ? 4'h9 : 4'h0;
        e.an1 = !lit1;
        e.dp1 = !lit1;
        e.fs1 = (n > 0) && (c == 0);
        return e;
    endfunction

    // Monitor: one expected record per falling edge while enabled
    always @(negedge clk) begin
        if (mon_en && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("d",           e.n, 32'(d),           32'(e.d));
            cmp("an_n",        e.n, 32'(an_n),        32'(e.an));
            cmp("dp_n",        e.n, 32'(dp_n),        32'(e.dp));
            cmp("frame_start", e.n, 32'(frame_start), 32'(e.fs));
            cmp("d1",          e.n, 32'(d1),          32'(e.d1));
            cmp("an1",         e.n, 32'(an1),         32'(e.an1));
            cmp("dp1",         e.n, 32'(dp1),         32'(e.dp1));
            cmp("fs1",         e.n, 32'(fs1),         32'(e.fs1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        n_cmp      = 0;
        n_bad      = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        data       = 32'hAAAAAAAA;
        en_mask    = 8'hFF;
        dp_mask    = 8'hFF;
        blink_mask = 8'h00;
        data1      = 4'h9;
        en1        = 1'b1;
        dpm1       = 1'b1;
        blink1     = 1'b0;

        #1;
        cmp("rst_an_n",  0, 32'(an_n),        32'hFF);
        cmp("rst_dp_n",  0, 32'(dp_n),        32'h1);
        cmp("rst_d",     0, 32'(d),           32'h0);
        cmp("rst_fs",    0, 32'(frame_start), 32'h0);
        cmp("rst_an1",   0, 32'(an1),         32'h1);

        for (int n = 0; n < 288; n++) q.push_back(model(n));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        for (int n = 0; n < 288; n++) begin
            @(negedge clk);
            if (n % 32 == 13 && n < 256) begin
                #1 apply(n / 32 + 1);
            end
        end
        @(negedge clk);
        #1 mon_en = 1'b0;
        cmp("drain1", 288, 32'(q.size()), 32'h0);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1 if (an_n !== 8'hFF) found = 1'b1;
        end
        cmp("lit_before_rst", 0, 32'(found), 32'h1);
        rst = 1'b1;
        #1;
        cmp("mid_rst_an_n", 0, 32'(an_n),        32'hFF);
        cmp("mid_rst_dp_n", 0, 32'(dp_n),        32'h1);
        cmp("mid_rst_d",    0, 32'(d),           32'h0);
        cmp("mid_rst_fs",   0, 32'(frame_start), 32'h0);
        @(posedge clk);
        #1 cmp("rst_hold_an_n", 0, 32'(an_n), 32'hFF);

        for (int n = 0; n < 32; n++) q.push_back(model(n));
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (33) @(negedge clk);
        #1 mon_en = 1'b0;
        cmp("drain2", 32, 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
